// File: rtl/fa_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fa_arbiter
// Brief   : Shares one external final_adder between NREQ requesters; three-state
//           IDLE/CALC/RESP sequencer with registered response and op counter.
//           Define FA_ARB_RR_EN for round-robin grant, else fixed priority (idx 0 wins).
// Revision: 1.0 - initial release
// ============================================================================
module fa_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [W-1:0]             adder_a,
  output logic [W-1:0]             adder_b,
  input  logic [W-1:0]             adder_s,
  input  logic                     adder_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy,
  output logic [15:0]              op_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_sum;
  logic            r_rsp_cout;
  logic [15:0]     r_op_count;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic            w_grant;

`ifdef FA_ARB_RR_EN
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_idx;

  function automatic logic [IDW-1:0] f_wrap(input logic [IDW:0] v);
    return IDW'((v >= (IDW+1)'(NREQ)) ? v - (IDW+1)'(NREQ) : v);
  endfunction

  // Scan upward from the pointer; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = f_wrap({1'b0, r_ptr} + (IDW+1)'(i));
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
`else
  always_comb begin
    w_found = |req_valid;
    w_win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_win = IDW'(i);
      end
    end
  end
`endif

  // Grant only from IDLE, so a response handshake can never overlap an accept.
  assign w_grant   = w_found && (r_state == S_IDLE) && rst_n;
  assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

  assign adder_a   = r_op_a;
  assign adder_b   = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign busy      = (r_state != S_IDLE);
  assign op_count  = r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_op_count  <= '0;
`ifdef FA_ARB_RR_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a  <= req_a[w_win*W +: W];
            r_op_b  <= req_b[w_win*W +: W];
            r_id    <= w_win;
`ifdef FA_ARB_RR_EN
            r_ptr   <= f_wrap({1'b0, w_win} + (IDW+1)'(1));
`endif
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rsp_sum   <= adder_s;
          r_rsp_cout  <= adder_cout;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fa_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fa_arbiter
// Brief   : Directed scoreboard bench for fa_arbiter with a behavioural adder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fa_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      adder_a;
  logic [W-1:0]      adder_b;
  logic [W-1:0]      adder_s;
  logic              adder_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;
  logic [15:0]       op_count;

  fa_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_s    (adder_s),
    .adder_cout (adder_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Stand-in for the shared final_adder.
  assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got id %0d sum 0x%0h, expected no response", rsp_id, rsp_sum);
      end else begin
        e = q.pop_front();
        check("rsp_id",   32'(rsp_id),   32'(e.id));
        check("rsp_sum",  32'(rsp_sum),  32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      end
    end
  end

  // Entered just after a rising edge with the DUT idle and rsp_ready high.
  task automatic do_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] s, input logic c);
    int cnt0;
    cnt0 = int'(op_count);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
    q.push_back('{id: 2'(idx), sum: s, cout: c});
    @(negedge clk);
    check("req_ready_grant", 32'(req_ready), 32'(4'b0001 << idx));
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check("req_ready_calc", 32'(req_ready), 32'd0);
    check("busy_calc", 32'(busy), 32'd1);
    check("rsp_valid_calc", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check("op_count_inc", 32'(op_count), 32'((cnt0 + 1) & 16'hFFFF));
  endtask

  logic [W-1:0] tab_a [NREQ];
  logic [W-1:0] tab_b [NREQ];

  initial begin
    int cnt0;
    bit done;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1 req_valid = 4'hF;
    #2;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_op_count",  32'(op_count),  32'd0);
    check("reset_rsp_sum",   32'(rsp_sum),   32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    check("reset_rsp_cout",  32'(rsp_cout),  32'd0);
    check("reset_adder_a",   32'(adder_a),   32'd0);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(0, 10'h03C, 10'h003, 10'h03F, 1'b0);
    do_req(2, 10'h3FF, 10'h001, 10'h000, 1'b1);
    do_req(2, 10'h3FF, 10'h3FF, 10'h3FE, 1'b1);

    // Back-pressure: hold rsp_ready low while another requester waits.
    cnt0 = int'(op_count);
    rsp_ready       = 1'b0;
    req_a[1*W +: W] = 10'h155;
    req_b[1*W +: W] = 10'h0AA;
    req_valid[1]    = 1'b1;
    q.push_back('{id: 2'd1, sum: 10'h1FF, cout: 1'b0});
    @(posedge clk); #1;
    req_valid[1]    = 1'b0;
    req_a[0*W +: W] = 10'h001;
    req_b[0*W +: W] = 10'h002;
    req_valid[0]    = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_id",    32'(rsp_id),    32'd1);
      check("stall_rsp_sum",   32'(rsp_sum),   32'h1FF);
      check("stall_rsp_cout",  32'(rsp_cout),  32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy",      32'(busy),      32'd1);
      check("stall_op_count",  32'(op_count),  32'(cnt0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("stall_op_count_inc", 32'(op_count), 32'(cnt0 + 1));
    check("stall_rsp_valid_drop", 32'(rsp_valid), 32'd0);

    // Reset during CALC discards the operation.
    @(posedge clk); #1;
    req_a[3*W +: W] = 10'h001;
    req_b[3*W +: W] = 10'h001;
    req_valid[3]    = 1'b1;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_calc_busy",      32'(busy),      32'd0);
    check("rst_calc_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_calc_op_count",  32'(op_count),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy",      32'(busy),      32'd0);
    end
    @(posedge clk); #1;
    do_req(3, 10'h00F, 10'h011, 10'h020, 1'b0);

    // All requesters valid at once, starting from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tab_a[0] = 10'h010; tab_b[0] = 10'h200;
    tab_a[1] = 10'h021; tab_b[1] = 10'h100;
    tab_a[2] = 10'h132; tab_b[2] = 10'h0CD;
    tab_a[3] = 10'h3F0; tab_b[3] = 10'h020;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = tab_a[i];
      req_b[i*W +: W] = tab_b[i];
    end
`ifdef FA_ARB_RR_EN
    q.push_back('{id: 2'd0, sum: 10'h210, cout: 1'b0});
    q.push_back('{id: 2'd1, sum: 10'h121, cout: 1'b0});
    q.push_back('{id: 2'd2, sum: 10'h1FF, cout: 1'b0});
    q.push_back('{id: 2'd3, sum: 10'h010, cout: 1'b1});
    q.push_back('{id: 2'd0, sum: 10'h210, cout: 1'b0});
`else
    for (int i = 0; i < 5; i++) q.push_back('{id: 2'd0, sum: 10'h210, cout: 1'b0});
`endif
    req_valid = 4'hF;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (op_count == 16'd5) begin
        req_valid = '0;
        done = 1'b1;
      end
    end
    check("all_valid_done", 32'(done), 32'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("all_valid_busy_end", 32'(busy), 32'd0);
    check("all_valid_op_count", 32'(op_count), 32'd5);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
